fetch_pc_unit: RTL and testbench
================================

# fetch_pc_unit

Fetch-stage PC and IF/ID register for the five-stage MIPS pipeline. Consumes the decode-stage redirect requests (register jumps jr/jalr with target already forwarded, immediate jumps j/jal, taken branches), selects the next PC, drives the instruction-memory address, and latches the fetched instruction and its PC into the IF/ID pipeline register. It honours the hazard unit's decode stall, and optionally squashes the slot after a redirect.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall_d  in  1  hazard-unit stall; freezes PC and IF/ID
- jump_reg  in  1  D-stage instruction is jr
- jump_and_link_reg  in  1  D-stage instruction is jalr
- npc_reg  in  32  forwarded register-jump target (rs value)
- jump_imm  in  1  D-stage instruction is j or jal
- branch_taken  in  1  D-stage branch resolved taken
- instr_d_imm  in  26  D-stage instr[25:0]; imm16 = [15:0]
- instr_f  in  32  instruction-memory read data for pc_f (combinational)
- pc_f  out  32  current fetch address
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc8_d  out  32  pc_d + 8, link address for jal/jalr
- redirect_d  out  1  redirect accepted this cycle
- pc_misaligned_f  out  1  pc_f[1:0] != 0

## Operation
- Targets, computed from pc_d: seq = pc_f + 4; br = pc_d + 4 + (sext(imm16) << 2); jimm = {(pc_d+4)[31:28], imm26, 2'b00}; jreg = npc_reg unmodified.
- Selection priority: jump_reg|jump_and_link_reg -> jreg; else jump_imm -> jimm; else branch_taken -> br; else seq. Decode makes these mutually exclusive; the priority exists only for determinism.
- redirect_d = ~stall_d & (jump_reg | jump_and_link_reg | jump_imm | branch_taken).
- Stall: when stall_d = 1, pc_f, instr_d and pc_d hold, and the redirect inputs are ignored. The hazard unit holds jr/jalr in D until npc_reg is valid, so a redirect is taken only in the first unstalled cycle.
- Without stall, at each edge: pc_f <= selected next PC; instr_d <= instr_f; pc_d <= pc_f (subject to Configuration).
- All arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Misaligned targets are loaded as-is. pc_misaligned_f is asserted combinationally for exception logic downstream; this block takes no other action on it.

## Timing
- Reset (synchronous, priority over stall): pc_f = RESET_PC, instr_d = 32'h0 (nop), pc_d = RESET_PC, pc8_d = RESET_PC + 8, redirect_d = 0, pc_misaligned_f = RESET_PC[1:0] != 0.
- Asserting reset mid-stall or mid-redirect discards the pending redirect.
- Redirect latency: the target appears on pc_f one edge after the D-stage instruction is unstalled with a redirect input high.
- IF/ID latency: one cycle from instr_f to instr_d.
- pc8_d and redirect_d are combinational from registers and inputs; no extra latency.

## Configuration
- DELAY_SLOT_EN defined: MIPS delay-slot semantics. On redirect, the instruction currently in F (pc_d + 4) is latched into IF/ID normally and executes.
- DELAY_SLOT_EN undefined: on redirect, IF/ID loads instr_d = 32'h0 with pc_d = pc_f, squashing the slot; a one-cycle bubble per taken redirect.
- Stall behaviour is identical in both builds.

## Structure
- Shared package holds:
  - PC_RESET_DEFAULT (32'h0000_3000)
  - NOP_INSTR (32'h0)
  - the next-PC select encoding (SEQ, BR, JIMM, JREG)
- One combinational sub-module, npc_select, computes the four targets and the priority mux. The top level holds the PC and IF/ID registers, stall and squash logic.

## Test plan
- Reset with stall_d = 1 held -> pc_f = 0x3000, instr_d = 0, pc8_d = 0x3008; on release pc_f steps 0x3004, 0x3008.
- jr with npc_reg = 0x0000_3400, pc_d = 0x3010 -> next pc_f = 0x3400, redirect_d = 1 for one cycle; with DELAY_SLOT_EN, instr_d = word at 0x3014; without it, instr_d = 0.
- jalr with npc_reg held during 2 stall cycles, then stall_d drops -> pc_f unchanged during the stall; redirect taken the cycle after release; pc8_d = pc_d + 8.
- Branch taken at pc_d = 0x3020 with imm16 = 16'hFFFE -> pc_f = 0x301C; with imm16 = 16'h0004 -> pc_f = 0x3034.
- j at pc_d = 0x3000 with imm26 = 0x0000C10 -> pc_f = 0x0000_3040. Simultaneous jump_reg and branch_taken -> npc_reg wins.
- npc_reg = 0x3002 -> pc_misaligned_f = 1 next cycle. pc_f = 0xFFFF_FFFC sequential -> wraps to 0x0.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and next-PC select encoding for the fetch stage.
package fetch_pc_unit_pkg;

   localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

   typedef enum logic [1:0] {
      SEQ  = 2'd0,
      BR   = 2'd1,
      JIMM = 2'd2,
      JREG = 2'd3
   } npc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_npc_select.sv
// Combinational next-PC target generation and priority select.
module npc_select
   import fetch_pc_unit_pkg::*;
(
   input  logic [31:0] pc_f_i,
   input  logic [31:0] pc_d_i,
   input  logic [31:0] npc_reg_i,
   input  logic        jump_reg_i,
   input  logic        jump_and_link_reg_i,
   input  logic        jump_imm_i,
   input  logic        branch_taken_i,
   input  logic [25:0] instr_imm_i,
   output logic [31:0] npc_o
);

   npc_sel_e    sel;
   logic [31:0] pc_d_plus4;
   logic [31:0] seq_target;
   logic [31:0] br_target;
   logic [31:0] jimm_target;

   assign pc_d_plus4  = pc_d_i + 32'd4;
   assign seq_target  = pc_f_i + 32'd4;
   assign br_target   = pc_d_plus4 + {{14{instr_imm_i[15]}}, instr_imm_i[15:0], 2'b00};
   assign jimm_target = {pc_d_plus4[31:28], instr_imm_i, 2'b00};

   // Decode keeps these exclusive; priority only makes overlap deterministic.
   always_comb begin
      sel = SEQ;
      if (jump_reg_i || jump_and_link_reg_i) sel = JREG;
      else if (jump_imm_i)                   sel = JIMM;
      else if (branch_taken_i)               sel = BR;
   end

   always_comb begin
      npc_o = seq_target;
      unique case (sel)
         SEQ:  npc_o = seq_target;
         BR:   npc_o = br_target;
         JIMM: npc_o = jimm_target;
         JREG: npc_o = npc_reg_i;
         default: npc_o = seq_target;
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and IF/ID pipeline register with stall and redirect.
// Build option DELAY_SLOT_EN: keep the delay-slot instruction instead of squashing it.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_d,
   input  logic        jump_reg,
   input  logic        jump_and_link_reg,
   input  logic [31:0] npc_reg,
   input  logic        jump_imm,
   input  logic        branch_taken,
   input  logic [25:0] instr_d_imm,
   input  logic [31:0] instr_f,
   output logic [31:0] pc_f,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic        redirect_d,
   output logic        pc_misaligned_f
);

   logic [31:0] pc_f_q;
   logic [31:0] instr_d_q;
   logic [31:0] pc_d_q;
   logic [31:0] npc;
   logic        redirect_req;

   npc_select u_npc_select (
      .pc_f_i              (pc_f_q),
      .pc_d_i              (pc_d_q),
      .npc_reg_i           (npc_reg),
      .jump_reg_i          (jump_reg),
      .jump_and_link_reg_i (jump_and_link_reg),
      .jump_imm_i          (jump_imm),
      .branch_taken_i      (branch_taken),
      .instr_imm_i         (instr_d_imm),
      .npc_o               (npc)
   );

   assign redirect_req = jump_reg | jump_and_link_reg | jump_imm | branch_taken;
   // Reset discards any pending redirect, so it is never reported during reset.
   assign redirect_d   = ~reset & ~stall_d & redirect_req;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_f_q    <= RESET_PC;
         instr_d_q <= NOP_INSTR;
         pc_d_q    <= RESET_PC;
      end else if (!stall_d) begin
         pc_f_q <= npc;
         pc_d_q <= pc_f_q;
`ifdef DELAY_SLOT_EN
         instr_d_q <= instr_f;
`else
         instr_d_q <= redirect_d ? NOP_INSTR : instr_f;
`endif
      end
   end

   assign pc_f            = pc_f_q;
   assign instr_d         = instr_d_q;
   assign pc_d            = pc_d_q;
   assign pc8_d           = pc_d_q + 32'd8;
   assign pc_misaligned_f = |pc_f_q[1:0];

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed vectors with hand-computed expectations.
module tb_fetch_pc_unit;

   logic        clk;
   logic        reset;
   logic        stall_d;
   logic        jump_reg;
   logic        jump_and_link_reg;
   logic [31:0] npc_reg;
   logic        jump_imm;
   logic        branch_taken;
   logic [25:0] instr_d_imm;
   logic [31:0] instr_f;
   logic [31:0] pc_f;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        redirect_d;
   logic        pc_misaligned_f;

   fetch_pc_unit dut (
      .clk               (clk),
      .reset             (reset),
      .stall_d           (stall_d),
      .jump_reg          (jump_reg),
      .jump_and_link_reg (jump_and_link_reg),
      .npc_reg           (npc_reg),
      .jump_imm          (jump_imm),
      .branch_taken      (branch_taken),
      .instr_d_imm       (instr_d_imm),
      .instr_f           (instr_f),
      .pc_f              (pc_f),
      .instr_d           (instr_d),
      .pc_d              (pc_d),
      .pc8_d             (pc8_d),
      .redirect_d        (redirect_d),
      .pc_misaligned_f   (pc_misaligned_f)
   );

   // Instruction memory model: each word is the bitwise inverse of its address.
   assign instr_f = ~pc_f;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] pc_f;
      logic [31:0] instr_d;
      logic [31:0] pc_d;
      logic        redir;
      string       name;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   bit   drv_done = 1'b0;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return ~a;
   endfunction

   // Word left in IF/ID after a redirect: the delay slot, or a squashed nop.
   function automatic logic [31:0] slot(input logic [31:0] a);
`ifdef DELAY_SLOT_EN
      return ~a;
`else
      return 32'h0;
`endif
   endfunction

   task automatic vec(input logic rst, input logic stl, input logic jr, input logic jalr,
                      input logic [31:0] npc, input logic ji, input logic bt,
                      input logic [25:0] imm, input bit chk,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pcd, input logic e_redir, input string name);
      exp_t e;
      @(negedge clk);
      reset = rst; stall_d = stl; jump_reg = jr; jump_and_link_reg = jalr;
      npc_reg = npc; jump_imm = ji; branch_taken = bt; instr_d_imm = imm;
      if (chk) begin
         e.pc_f = e_pc; e.instr_d = e_instr; e.pc_d = e_pcd; e.redir = e_redir; e.name = name;
         q.push_back(e);
      end
   endtask

   // Monitor: samples just before each rising edge, after inputs have settled.
   initial begin
      exp_t e;
      logic [31:0] e_pc8;
      logic        e_mis;
      forever begin
         @(negedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            e_pc8 = e.pc_d + 32'd8;
            e_mis = (e.pc_f[1:0] != 2'b00);
            n_vec++;
            if (pc_f !== e.pc_f || instr_d !== e.instr_d || pc_d !== e.pc_d ||
                pc8_d !== e_pc8 || redirect_d !== e.redir || pc_misaligned_f !== e_mis) begin
               n_miss++;
               $display("FAIL %s: got pc_f=%h instr_d=%h pc_d=%h pc8_d=%h redir=%b mis=%b exp pc_f=%h instr_d=%h pc_d=%h pc8_d=%h redir=%b mis=%b",
                        e.name, pc_f, instr_d, pc_d, pc8_d, redirect_d, pc_misaligned_f,
                        e.pc_f, e.instr_d, e.pc_d, e_pc8, e.redir, e_mis);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; stall_d = 1'b1; jump_reg = 1'b0; jump_and_link_reg = 1'b0;
      npc_reg = '0; jump_imm = 1'b0; branch_taken = 1'b0; instr_d_imm = '0;

      //   rst stl jr jalr npc            ji bt imm26        chk pc_f           instr_d              pc_d           redir name
      vec(1, 1, 0, 0, 32'h0,          0, 0, 26'h0,       0, 32'h0,         32'h0,               32'h0,         0, "pre_reset");
      vec(1, 1, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3000,      32'h0,               32'h3000,      0, "reset_stall");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3000,      32'h0,               32'h3000,      0, "release");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3004,      imem(32'h3000),      32'h3000,      0, "seq_3004");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3008,      imem(32'h3004),      32'h3004,      0, "seq_3008");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h300C,      imem(32'h3008),      32'h3008,      0, "seq_300c");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3010,      imem(32'h300C),      32'h300C,      0, "seq_3010");
      vec(0, 0, 1, 0, 32'h3400,       0, 0, 26'h0,       1, 32'h3014,      imem(32'h3010),      32'h3010,      1, "jr_issue");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3400,      slot(32'h3014),      32'h3014,      0, "jr_target");
      vec(0, 1, 0, 1, 32'h3100,       0, 0, 26'h0,       1, 32'h3404,      imem(32'h3400),      32'h3400,      0, "jalr_stall1");
      vec(0, 1, 0, 1, 32'h3100,       0, 0, 26'h0,       1, 32'h3404,      imem(32'h3400),      32'h3400,      0, "jalr_stall2");
      vec(0, 0, 0, 1, 32'h3100,       0, 0, 26'h0,       1, 32'h3404,      imem(32'h3400),      32'h3400,      1, "jalr_release");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3100,      slot(32'h3404),      32'h3404,      0, "jalr_target");
      vec(0, 0, 1, 0, 32'h3020,       0, 0, 26'h0,       1, 32'h3104,      imem(32'h3100),      32'h3100,      1, "jr_to_3020");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3020,      slot(32'h3104),      32'h3104,      0, "at_3020");
      vec(0, 0, 0, 0, 32'h0,          0, 1, 26'h0FFFE,   1, 32'h3024,      imem(32'h3020),      32'h3020,      1, "br_back");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h301C,      slot(32'h3024),      32'h3024,      0, "br_back_tgt");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3020,      imem(32'h301C),      32'h301C,      0, "seq_3020");
      vec(0, 0, 0, 0, 32'h0,          0, 1, 26'h00004,   1, 32'h3024,      imem(32'h3020),      32'h3020,      1, "br_fwd");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3034,      slot(32'h3024),      32'h3024,      0, "br_fwd_tgt");
      vec(1, 0, 1, 0, 32'h5000,       0, 0, 26'h0,       1, 32'h3038,      imem(32'h3034),      32'h3034,      0, "reset_mid_jr");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3000,      32'h0,               32'h3000,      0, "after_reset");
      vec(0, 0, 0, 0, 32'h0,          1, 0, 26'h0000C10, 1, 32'h3004,      imem(32'h3000),      32'h3000,      1, "j_issue");
      vec(0, 0, 1, 0, 32'h3002,       0, 1, 26'h00004,   1, 32'h3040,      slot(32'h3004),      32'h3004,      1, "jr_beats_br");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h3002,      slot(32'h3040),      32'h3040,      0, "misaligned");
      vec(0, 0, 1, 0, 32'hFFFF_FFFC,  0, 0, 26'h0,       1, 32'h3006,      imem(32'h3002),      32'h3002,      1, "jr_to_top");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'hFFFF_FFFC, slot(32'h3006),      32'h3006,      0, "at_top");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h0,         imem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 0, "wrap_zero");
      vec(0, 1, 0, 0, 32'h0,          0, 1, 26'h00004,   1, 32'h4,         imem(32'h0),         32'h0,         0, "stall_ignores_br");
      vec(0, 0, 0, 0, 32'h0,          0, 0, 26'h0,       1, 32'h4,         imem(32'h0),         32'h0,         0, "stall_held");
      drv_done = 1'b1;

      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      #5;
      if (q.size() > 0) begin
         n_miss++;
         $display("FAIL drain: %0d expected vectors never checked, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
